mux_nto1_pipe: RTL

Parametrised N-input, WIDTH-bit multiplexer with a valid/ready handshake on every input and on the output, plus a one-deep registered output stage. Selection is either fixed by the `sel` input or round-robin across the valid inputs. It supersedes the combinational 2:1 mux wherever the datapath needs back-pressure, a registered output, or fair sharing between sources.

---
 rtl/mux_nto1_pipe_if.sv | 27 ++
 rtl/mux_nto1_pipe.sv | 118 +++++++++++
 2 files changed

// File: rtl/mux_nto1_pipe_if.sv
// rtl/mux_nto1_pipe_if.sv - handshake bundle for the N:1 pipelined mux
interface mux_nto1_pipe_if #(
  parameter int WIDTH = 8,
  parameter int N     = 4
);
  localparam int SELW = $clog2(N);

  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [SELW-1:0]    sel;
  logic               mode;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic               out_ready;
  logic [SELW-1:0]    out_ch;

  modport master (
    output in_data, in_valid, sel, mode, out_ready,
    input  in_ready, out_data, out_valid, out_ch
  );

  modport slave (
    input  in_data, in_valid, sel, mode, out_ready,
    output in_ready, out_data, out_valid, out_ch
  );
endinterface

// File: rtl/mux_nto1_pipe.sv
// rtl/mux_nto1_pipe.sv - N:1 valid/ready mux, fixed or round-robin select, one-deep output register
// Optional beat counter (beat_cnt, cnt_clr) enabled by defining MUX_BEAT_CNT_EN.
module mux_nto1_pipe #(
  parameter int WIDTH = 8,
  parameter int N     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef MUX_BEAT_CNT_EN
  input  logic              cnt_clr,
  output logic [15:0]       beat_cnt,
`endif
  mux_nto1_pipe_if.slave    bus
);
  localparam int SELW = $clog2(N);
  localparam logic [SELW:0]   NUM  = N[SELW:0];
  localparam logic [SELW-1:0] LAST = SELW'(N - 1);

  logic [SELW-1:0]  rr_q, rr_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_ch_q, out_ch_d;

  logic             accept;
  logic             gnt_valid;
  logic [SELW-1:0]  gnt;
  logic [SELW:0]    cand;
  logic [N-1:0]     in_ready_w;
  logic             xfer;
  logic [WIDTH-1:0] sel_data;

  assign accept = !out_valid_q || bus.out_ready;

  // Round-robin: walk from rr_q upward; lowest offset wins, so scan offsets high to low.
  always_comb begin
    gnt_valid = 1'b0;
    gnt       = '0;
    cand      = '0;
    if (!bus.mode) begin
      gnt_valid = ({1'b0, bus.sel} < NUM);
      gnt       = bus.sel;
    end else begin
      for (int k = N - 1; k >= 0; k--) begin
        cand = {1'b0, rr_q} + (SELW + 1)'(k);
        if (cand >= NUM) cand = cand - NUM;
        if (bus.in_valid[cand[SELW-1:0]]) begin
          gnt_valid = 1'b1;
          gnt       = cand[SELW-1:0];
        end
      end
    end
  end

  always_comb begin
    in_ready_w = '0;
    if (gnt_valid && rst_n) in_ready_w[gnt] = accept;
  end

  assign xfer = |(in_ready_w & bus.in_valid);

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt == SELW'(i)) sel_data = bus.in_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    rr_d        = rr_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      out_ch_d    = gnt;
      if (bus.mode) rr_d = (gnt == LAST) ? '0 : gnt + 1'b1;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      rr_q        <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      rr_q        <= rr_d;
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;

`ifdef MUX_BEAT_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) cnt_d = '0;
    else if (out_valid_q && bus.out_ready && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign beat_cnt = cnt_q;
`endif
endmodule
